mem_lsu: RTL
============

Name: mem_lsu

Overview:
- Memory-stage load/store unit for the pipelined RISC-V core.
- Consumes the decoded MemOp/MemWr/MemtoReg control produced in ID and carried down the pipeline.
- Turns one load or store into a single word-aligned request/grant/response transaction on the data-memory bus.
- Stalls the pipeline while the access is outstanding, then returns the byte/half/word result, sign- or zero-extended per MemOp.

Parameters:
- ADDR_W, 32, address width of the pipeline and bus.
- TIMEOUT, 255, maximum cycles spent in REQ or WAIT before the access aborts with a bus error.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- op_valid  in  1  MEM-stage instruction valid; inputs below are held stable while stall=1.
- MemWr  in  1  store.
- MemtoReg  in  1  load.
- MemOp  in  3  access type: 000 word, 001 byte signed, 010 half signed, 101 byte unsigned, 110 half unsigned.
- addr  in  ADDR_W  effective address (ALU result).
- wdata  in  32  store data (rs2).
- stall  out  1  hold the pipeline upstream of MEM.
- done  out  1  one-cycle pulse: access complete.
- rdata  out  32  extended load result, valid when done=1 on a load.
- exc_misalign  out  1  one-cycle pulse: misaligned or illegal access rejected.
- exc_bus  out  1  one-cycle pulse: timeout abort.
- mem_req  out  1  bus request.
- mem_we  out  1  bus write.
- mem_addr  out  ADDR_W  word-aligned address (low 2 bits 0).
- mem_wmask  out  4  byte-lane write enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_gnt  in  1  request accepted.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read word.

Behaviour:
- Reset: state=IDLE. All outputs 0, including rdata and the timeout counter.
- Access: acc = op_valid & (MemWr | MemtoReg). MemWr has priority if both are set.
- Size comes from MemOp[1:0]: 00 word, 01 byte, 10 half, 11 illegal. MemOp[2]=1 selects zero-extension; MemOp=100 is illegal.
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
- States: IDLE, REQ, WAIT, DONE, ERR.
- IDLE, acc, illegal or misaligned -> ERR. No bus activity.
- IDLE, acc, legal -> REQ. Bus outputs are registered on this edge.
- REQ: mem_req=1, bus outputs held.
  - mem_gnt and store -> DONE.
  - mem_gnt and load -> WAIT.
- WAIT: mem_req=0. On mem_rvalid -> DONE; rdata is extracted from lane addr[1:0] and extended, then registered.
- mem_rvalid in the same cycle as mem_gnt: treated as gnt only; the response is expected later.
- DONE: done=1 for one cycle, rdata held, then -> IDLE.
- ERR: exc_misalign=1 for one cycle, then -> IDLE. rdata is unchanged.
- Timeout: counter clears on entering REQ and increments each cycle in REQ/WAIT. When it reaches TIMEOUT: exc_bus=1 for one cycle, mem_req drops, -> IDLE. A late mem_rvalid is then ignored in IDLE.
- stall = acc & ~(state==DONE | state==ERR | exc_bus cycle).
  - stall is 1 combinationally in the IDLE cycle an access arrives.
  - The pipeline advances on the completion cycle; the next access can be accepted the cycle after.
- Load latency with immediate gnt and rvalid one cycle later: accept, REQ, WAIT, DONE. Four cycles, stall high for three.
- Stores:
  - mem_wmask: byte = 1<<addr[1:0]; half = 0011<<addr[1:0]; word = 1111.
  - mem_wdata: byte replicated x4, half x2.
- Loads: mem_wmask=0, mem_we=0.
- Non-access (op_valid=0 or neither flag): stall=0, no state change.
- rst_n low mid-transaction: immediate IDLE, mem_req=0. An outstanding bus response after reset is ignored.
- op_valid dropping mid-transaction (flush): the transaction still completes. done and exc pulses still fire; the pipeline ignores them.

Test Plan:
- lb at addr 0x1003, MemOp=001, mem_rdata=0x80FF_1234, rvalid one cycle after gnt -> rdata=0xFFFF_FF80, done on cycle 4, stall high cycles 1-3.
- lhu at 0x2002, MemOp=110, mem_rdata=0x8001_0000 -> rdata=0x0000_8001, mem_addr=0x2000, mem_wmask=0.
- sh at 0x3002, wdata=0xDEAD_BEEF, gnt held low 5 cycles -> mem_req held 6 cycles, mem_wmask=1100, mem_wdata=0xBEEF_BEEF, mem_we=1, done after gnt.
- lw at 0x4001 -> no mem_req; exc_misalign pulse on cycle 2; stall 1 only in cycle 1. MemOp=011 load -> same response.
- lw with gnt but no rvalid, TIMEOUT=8 -> exc_bus pulses after 8 cycles in REQ/WAIT; rvalid arriving afterwards produces no done.
- rst_n asserted while in WAIT -> outputs 0 immediately. Next sb at 0x5000 with wdata=0x12 -> mem_wmask=0001, mem_wdata=0x1212_1212.

Source files
------------

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit, one word-aligned req/gnt/rvalid bus transaction per access.
// Latency: load = accept, REQ, WAIT, DONE (4 cycles min); store = accept, REQ, DONE (3 cycles min).
// Backpressure: stall held while the access is outstanding; a gnt/rvalid-less bus aborts after TIMEOUT cycles.
// Ports: clk/rst_n; pipeline side op_valid, MemWr, MemtoReg, MemOp, addr, wdata -> stall, done, rdata,
//        exc_misalign, exc_bus; bus side mem_req, mem_we, mem_addr, mem_wmask, mem_wdata <- mem_gnt,
//        mem_rvalid, mem_rdata.
module mem_lsu #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  input  logic              MemWr,
  input  logic              MemtoReg,
  input  logic [2:0]        MemOp,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              exc_misalign,
  output logic              exc_bus,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wmask,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, ERR} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          acc, bad, timeout, start;
  logic [1:0]    size;
  logic [1:0]    lane_q, size_q;
  logic          uns_q;
  logic [3:0]    wmask_d;
  logic [31:0]   wdata_d, sh_word, ld_ext;

  assign acc  = op_valid & (MemWr | MemtoReg);
  assign size = MemOp[1:0];

  // Illegal encodings (size 11, or zero-extended word) and misaligned half/word accesses
  assign bad = (size == 2'b11) | (MemOp == 3'b100) |
               ((size == 2'b10) & addr[0]) |
               ((size == 2'b00) & (addr[1:0] != 2'b00));

  // Timeout wins over a same-cycle gnt/rvalid: the abort cycle never talks to the bus
  assign timeout = ((state == REQ) || (state == WAIT)) && (cnt == CW'(TIMEOUT));
  assign start   = (state == IDLE) && acc && !bad;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; REQ looks only at gnt, so an rvalid coincident with gnt is ignored
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (acc) state_nxt = bad ? ERR : REQ;
      REQ:     if (timeout) state_nxt = IDLE;
               else if (mem_gnt) state_nxt = mem_we ? DONE : WAIT;
      WAIT:    if (timeout) state_nxt = IDLE;
               else if (mem_rvalid) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    mem_req      = (state == REQ) && !timeout;
    done         = (state == DONE);
    exc_misalign = (state == ERR);
    exc_bus      = timeout;
    stall        = acc & ~((state == DONE) | (state == ERR) | timeout);
  end

  // Store lane enables and replicated data
  always_comb begin
    wmask_d = 4'b1111;
    wdata_d = wdata;
    case (size)
      2'b01: begin
        wmask_d = 4'b0001 << addr[1:0];
        wdata_d = {4{wdata[7:0]}};
      end
      2'b10: begin
        wmask_d = 4'b0011 << addr[1:0];
        wdata_d = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Bus fields and access attributes are captured at accept, so a flush cannot disturb them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wmask <= 4'b0;
      mem_wdata <= 32'b0;
      lane_q    <= 2'b0;
      size_q    <= 2'b0;
      uns_q     <= 1'b0;
    end else if (start) begin
      mem_we    <= MemWr;
      mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
      mem_wmask <= MemWr ? wmask_d : 4'b0;
      mem_wdata <= MemWr ? wdata_d : 32'b0;
      lane_q    <= addr[1:0];
      size_q    <= size;
      uns_q     <= MemOp[2];
    end
  end

  // Timeout counter: cleared on entering REQ, counts every REQ/WAIT cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              cnt <= '0;
    else if (start)                          cnt <= '0;
    else if ((state == REQ) || (state == WAIT)) cnt <= cnt + 1'b1;
  end

  // Load extraction: shift the addressed lane down, then extend
  assign sh_word = mem_rdata >> {lane_q, 3'b000};

  always_comb begin
    ld_ext = mem_rdata;
    case (size_q)
      2'b01:   ld_ext = uns_q ? {24'b0, sh_word[7:0]}  : {{24{sh_word[7]}},  sh_word[7:0]};
      2'b10:   ld_ext = uns_q ? {16'b0, sh_word[15:0]} : {{16{sh_word[15]}}, sh_word[15:0]};
      default: ld_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       rdata <= 32'b0;
    else if ((state == WAIT) && mem_rvalid && !timeout) rdata <= ld_ext;
  end

endmodule
